// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its environment: hazard controls,
// EX-stage redirect, the instruction-memory read port and the IF/ID register outputs.
interface if_stage_if;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fetch_fault_d;

  modport master (
    input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
    output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault_d
  );

  modport slave (
    output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
    input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault_d
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, reads instruction memory
// combinationally and loads the IF/ID register, honouring stall/flush/redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  bus
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
  logic        valid_d_q, valid_d_d;
  logic        fetch_fault_d_q, fetch_fault_d_d;

  logic [31:0] pc_plus4_f;
  logic        fault_f;

  assign pc_plus4_f = pc_f_q + 32'd4;
  // Word index compared zero-extended so the bound check spans the full 30-bit index.
  assign fault_f    = (pc_f_q[1:0] != 2'b00) || ({2'b00, pc_f_q[31:2]} >= IMEM_LIMIT);

  always_comb begin
    pc_f_d = pc_plus4_f;
    if (bus.pc_src_e) begin
      pc_f_d = bus.pc_target_e;
    end else if (bus.stall_f) begin
      pc_f_d = pc_f_q;
    end
  end

  always_comb begin
    instr_d_d       = instr_d_q;
    pc_d_d          = pc_d_q;
    pc_plus4_d_d    = pc_plus4_d_q;
    valid_d_d       = valid_d_q;
    fetch_fault_d_d = fetch_fault_d_q;
    if (bus.flush_d) begin
      instr_d_d       = NOP_INSTR;
      pc_d_d          = 32'd0;
      pc_plus4_d_d    = 32'd0;
      valid_d_d       = 1'b0;
      fetch_fault_d_d = 1'b0;
    end else if (!bus.stall_d) begin
      instr_d_d       = fault_f ? NOP_INSTR : bus.imem_rdata;
      pc_d_d          = pc_f_q;
      pc_plus4_d_d    = pc_plus4_f;
      valid_d_d       = 1'b1;
      fetch_fault_d_d = fault_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q          <= RESET_PC;
      instr_d_q       <= NOP_INSTR;
      pc_d_q          <= 32'd0;
      pc_plus4_d_q    <= 32'd0;
      valid_d_q       <= 1'b0;
      fetch_fault_d_q <= 1'b0;
    end else begin
      pc_f_q          <= pc_f_d;
      instr_d_q       <= instr_d_d;
      pc_d_q          <= pc_d_d;
      pc_plus4_d_q    <= pc_plus4_d_d;
      valid_d_q       <= valid_d_d;
      fetch_fault_d_q <= fetch_fault_d_d;
    end
  end

  assign bus.imem_addr     = pc_f_q;
  assign bus.instr_d       = instr_d_q;
  assign bus.pc_d          = pc_d_q;
  assign bus.pc_plus4_d    = pc_plus4_d_q;
  assign bus.valid_d       = valid_d_q;
  assign bus.fetch_fault_d = fetch_fault_d_q;

endmodule
